// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper command path: FSM encoding, move
// result codes and default field widths.
package stepper_pkg;

   // Default widths; the top exposes these as overridable parameters.
   localparam int DEF_STEP_W = 16;
   localparam int DEF_PER_W  = 16;
   localparam int DEF_POS_W  = 24;

   // Sequencer states
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // Result of the last move, reported on status
   localparam logic [1:0] ST_OK    = 2'b00;
   localparam logic [1:0] ST_ABORT = 2'b01;
   localparam logic [1:0] ST_LIMIT = 2'b10;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs (limit switches).
module sync_2ff
   import stepper_pkg::*;
#(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;

   // Two-stage capture; both stages clear to 0 so limits read inactive after reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/step_move_sequencer.sv
// Move command sequencer in front of the 4-phase stepper driver: latches a
// move, emits one step strobe per period, tracks signed position and reports
// how each move ended (ok / aborted / limit).
module step_move_sequencer
   import stepper_pkg::*;
#(
   parameter int STEP_W = DEF_STEP_W,
   parameter int PER_W  = DEF_PER_W,
   parameter int POS_W  = DEF_POS_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_dir,
   input  logic [STEP_W-1:0] cmd_steps,
   input  logic [PER_W-1:0]  cmd_period,
   input  logic              abort,
   input  logic              lim_cw,
   input  logic              lim_ccw,
   input  logic              pos_clr,
   output logic              en,
   output logic              cw,
   output logic              step_stb,
   output logic              busy,
   output logic              done,
   output logic [1:0]        status,
   output logic [POS_W-1:0]  pos
);

   logic [1:0]        state_q, state_d;
   logic              dir_q, dir_d;
   logic [PER_W-1:0]  per_q, per_d;
   logic [PER_W-1:0]  cnt_q, cnt_d;
   logic [STEP_W-1:0] rem_q, rem_d;
   logic [1:0]        status_q, status_d;
   logic [POS_W-1:0]  pos_q, pos_d;

   logic lim_cw_s, lim_ccw_s;
   logic lim_hit;
   logic in_run;
   logic stb;
   logic accept;

   sync_2ff #(.W(1)) u_sync_cw (
      .clk (clk),
      .rst (rst),
      .d   (lim_cw),
      .q   (lim_cw_s)
   );

   sync_2ff #(.W(1)) u_sync_ccw (
      .clk (clk),
      .rst (rst),
      .d   (lim_ccw),
      .q   (lim_ccw_s)
   );

   // Only the limit in the direction of travel stops a move.
   assign lim_hit = dir_q ? lim_cw_s : lim_ccw_s;
   assign in_run  = (state_q == S_RUN);
   // Abort and limit both outrank the strobe in the same cycle.
   assign stb     = in_run && !abort && !lim_hit && (cnt_q == '0);
   // Held low during reset so nothing upstream sees a ready before release.
   assign cmd_ready = (state_q == S_IDLE) && rst;
   assign accept    = cmd_valid && cmd_ready;

   // Next-state: command latch, period countdown, step accounting, result code.
   always_comb begin
      state_d  = state_q;
      dir_d    = dir_q;
      per_d    = per_q;
      cnt_d    = cnt_q;
      rem_d    = rem_q;
      status_d = status_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               dir_d = cmd_dir;
               // A zero period would never count down; run it as one cycle.
               per_d = (cmd_period == '0) ? PER_W'(1) : cmd_period;
               cnt_d = per_d - PER_W'(1);
               rem_d = cmd_steps;
               if (cmd_steps == '0) begin
                  state_d  = S_DONE;
                  status_d = ST_OK;
               end else begin
                  state_d = S_RUN;
               end
            end
         end
         S_RUN: begin
            if (abort) begin
               state_d  = S_DONE;
               status_d = ST_ABORT;
            end else if (lim_hit) begin
               state_d  = S_DONE;
               status_d = ST_LIMIT;
            end else if (cnt_q == '0) begin
               cnt_d = per_q - PER_W'(1);
               rem_d = rem_q - STEP_W'(1);
               if (rem_q == STEP_W'(1)) begin
                  state_d  = S_DONE;
                  status_d = ST_OK;
               end
            end else begin
               cnt_d = cnt_q - PER_W'(1);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Position follows the strobes one cycle later; clear wins over a step.
   always_comb begin
      pos_d = pos_q;
      if (pos_clr)
         pos_d = '0;
      else if (stb)
         pos_d = dir_q ? (pos_q + POS_W'(1)) : (pos_q - POS_W'(1));
   end

   // State registers; reset drops en at once and suppresses any done pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         dir_q    <= 1'b0;
         per_q    <= '0;
         cnt_q    <= '0;
         rem_q    <= '0;
         status_q <= ST_OK;
         pos_q    <= '0;
      end else begin
         state_q  <= state_d;
         dir_q    <= dir_d;
         per_q    <= per_d;
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         status_q <= status_d;
         pos_q    <= pos_d;
      end
   end

   assign en       = in_run;
   assign cw       = dir_q;
   assign step_stb = stb;
   assign busy     = (state_q != S_IDLE);
   assign done     = (state_q == S_DONE);
   assign status   = status_q;
   // Two's-complement position; wraps naturally at the POS_W limits.
   assign pos      = pos_q;

endmodule

// File: tb/tb_step_move_sequencer.sv
// Directed bench for step_move_sequencer: hand-computed strobe timing,
// completion status and position for each scenario.
module tb_step_move_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_dir = 1'b0;
   logic [15:0] cmd_steps = '0;
   logic [15:0] cmd_period = '0;
   logic        abort = 1'b0;
   logic        lim_cw = 1'b0;
   logic        lim_ccw = 1'b0;
   logic        pos_clr = 1'b0;
   logic        en, cw, step_stb, busy, done;
   logic [1:0]  status;
   logic [23:0] pos;

   int n_chk  = 0;
   int n_fail = 0;

   step_move_sequencer #(.STEP_W(16), .PER_W(16), .POS_W(24)) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_dir    (cmd_dir),
      .cmd_steps  (cmd_steps),
      .cmd_period (cmd_period),
      .abort      (abort),
      .lim_cw     (lim_cw),
      .lim_ccw    (lim_ccw),
      .pos_clr    (pos_clr),
      .en         (en),
      .cw         (cw),
      .step_stb   (step_stb),
      .busy       (busy),
      .done       (done),
      .status     (status),
      .pos        (pos)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle; inputs and checks happen 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer a command in the current cycle T; returns positioned in cycle T+1.
   task automatic issue(input logic d, input logic [15:0] s, input logic [15:0] p);
      cmd_dir    = d;
      cmd_steps  = s;
      cmd_period = p;
      cmd_valid  = 1'b1;
      chk("accept_ready", cmd_ready, 1);
      tick();
      cmd_valid = 1'b0;
   endtask

   // From the current cycle (k=1), count strobes until done; dcyc=-1 on timeout.
   task automatic run(input int maxc, output int nstb, output int dcyc);
      nstb = 0;
      dcyc = -1;
      for (int k = 1; k <= maxc; k++) begin
         if (step_stb) nstb++;
         if (done) begin
            dcyc = k;
            break;
         end
         tick();
      end
   endtask

   initial begin
      int n, d;

      // Reset state
      tick();
      tick();
      chk("rst_en", en, 0);
      chk("rst_cw", cw, 0);
      chk("rst_stb", step_stb, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_status", status, 0);
      chk("rst_pos", pos, 0);
      chk("rst_ready", cmd_ready, 0);
      rst = 1'b1;
      #1;
      chk("rel_ready", cmd_ready, 1);
      tick();

      // cw, 3 steps, period 4: strobes at T+4/8/12, done at T+13
      issue(1'b1, 16'd3, 16'd4);
      for (int k = 1; k <= 13; k++) begin
         chk($sformatf("s1_stb_%0d", k), step_stb, (k == 4 || k == 8 || k == 12));
         chk($sformatf("s1_en_%0d", k), en, (k <= 12));
         chk($sformatf("s1_done_%0d", k), done, (k == 13));
         chk($sformatf("s1_busy_%0d", k), busy, 1);
         if (k == 1) chk("s1_cw", cw, 1);
         if (k == 13) chk("s1_status", status, 2'b00);
         tick();
      end
      chk("s1_pos", pos, 3);
      chk("s1_idle", busy, 0);

      // ccw, 5 steps, period 0 from pos 0: wraps to -5
      pos_clr = 1'b1;
      tick();
      pos_clr = 1'b0;
      chk("s2_clr", pos, 0);
      issue(1'b0, 16'd5, 16'd0);
      run(20, n, d);
      chk("s2_nstb", n, 5);
      chk("s2_done_cyc", d, 6);
      chk("s2_status", status, 2'b00);
      tick();
      chk("s2_pos", pos, 32'h00FF_FFFB);

      // cw, 10 steps, period 2; abort on the 4th strobe cycle (T+8)
      pos_clr = 1'b1;
      tick();
      pos_clr = 1'b0;
      issue(1'b1, 16'd10, 16'd2);
      n = 0;
      for (int k = 1; k <= 7; k++) begin
         if (k == 3) begin
            cmd_valid = 1'b1;
            cmd_steps = 16'd7;
            chk("s3_ready_run", cmd_ready, 0);
         end else begin
            cmd_valid = 1'b0;
         end
         if (step_stb) n++;
         tick();
      end
      chk("s3_nstb", n, 3);
      abort = 1'b1;
      #1;
      chk("s3_abort_stb", step_stb, 0);
      chk("s3_abort_en", en, 1);
      tick();
      abort = 1'b0;
      chk("s3_done", done, 1);
      chk("s3_status", status, 2'b01);
      tick();
      chk("s3_pos", pos, 3);
      tick();
      chk("s3_no_accept", busy, 0);

      // cw, lim_cw raised at T+5: one more strobe (T+6), done at T+8
      pos_clr = 1'b1;
      tick();
      pos_clr = 1'b0;
      issue(1'b1, 16'd20, 16'd2);
      repeat (4) tick();
      lim_cw = 1'b1;
      run(10, n, d);
      chk("s4_nstb_after", n, 1);
      chk("s4_done_cyc", d, 4);
      chk("s4_status", status, 2'b10);
      lim_cw = 1'b0;
      tick();
      chk("s4_pos", pos, 3);
      repeat (3) tick();

      // Opposite limit ignored; then a ccw move starting on its active limit
      lim_ccw = 1'b1;
      repeat (3) tick();
      issue(1'b1, 16'd3, 16'd1);
      run(10, n, d);
      chk("s5_nstb", n, 3);
      chk("s5_done_cyc", d, 4);
      chk("s5_status", status, 2'b00);
      tick();
      issue(1'b0, 16'd4, 16'd1);
      run(10, n, d);
      chk("s5_lim_nstb", n, 0);
      chk("s5_lim_done_cyc", d, 2);
      chk("s5_lim_status", status, 2'b10);
      lim_ccw = 1'b0;
      tick();
      chk("s5_pos", pos, 6);
      repeat (3) tick();

      // Zero-step move: done at T+1, no enable, position untouched
      issue(1'b1, 16'd0, 16'd5);
      chk("s6_done", done, 1);
      chk("s6_en", en, 0);
      chk("s6_status", status, 2'b00);
      tick();
      chk("s6_pos", pos, 6);
      chk("s6_idle", busy, 0);

      // pos_clr coincident with the first strobe of a 2-step, period-3 move
      issue(1'b1, 16'd2, 16'd3);
      tick();
      tick();
      chk("s7_stb1", step_stb, 1);
      pos_clr = 1'b1;
      tick();
      pos_clr = 1'b0;
      chk("s7_clr_wins", pos, 0);
      tick();
      tick();
      chk("s7_stb2", step_stb, 1);
      tick();
      chk("s7_done", done, 1);
      chk("s7_pos", pos, 1);
      tick();

      // Abort on first cycle of a period-1 move: strobe suppressed, status 01
      issue(1'b0, 16'd3, 16'd1);
      abort = 1'b1;
      #1;
      chk("s8_abort_stb", step_stb, 0);
      tick();
      abort = 1'b0;
      chk("s8_status", status, 2'b01);
      tick();
      chk("s8_pos", pos, 1);

      // Reset mid-run clears outputs asynchronously, no done pulse
      issue(1'b1, 16'd5, 16'd2);
      tick();
      chk("s9_stb", step_stb, 1);
      rst = 1'b0;
      #1;
      chk("s9_en", en, 0);
      chk("s9_stb_rst", step_stb, 0);
      chk("s9_pos", pos, 0);
      chk("s9_status", status, 0);
      chk("s9_busy", busy, 0);
      tick();
      chk("s9_done", done, 0);
      rst = 1'b1;
      tick();
      chk("s9_ready", cmd_ready, 1);
      chk("s9_idle", busy, 0);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
